// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port owner: merges ALU and LSU writebacks, tracks pending
// destination registers and aligns read-during-write forwarding with RAM read data.
module rf_writeback_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_wdata,
  input  logic        i_lsu_valid,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic        o_fwd1_en,
  output logic [31:0] o_fwd1_data,
  output logic        o_fwd2_en,
  output logic [31:0] o_fwd2_data,
  output logic [31:0] o_pending,
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          r_we;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic          r_fwd1_en;
  logic [31:0]   r_fwd1_data;
  logic          r_fwd2_en;
  logic [31:0]   r_fwd2_data;
  logic [31:0]   r_pending;

  logic          w_lsu_ready;
  logic          w_fifo_ne;
  logic          w_alu_sel;
  logic          w_lsu_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_sel_we;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_pending_nxt;

  assign w_lsu_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_fifo_ne   = (r_count != {CW{1'b0}});
  assign w_alu_sel   = i_alu_valid && (i_alu_rd != 5'd0);
  assign w_lsu_acc   = i_lsu_valid && w_lsu_ready && (i_lsu_rd != 5'd0);
  // LSU writes queue behind any older queued entry or a competing ALU write.
  assign w_push      = w_lsu_acc && (w_alu_sel || w_fifo_ne);
  assign w_pop       = !w_alu_sel && w_fifo_ne;

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_rd   = 5'd0;
    w_sel_data = 32'd0;
    if (w_alu_sel) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = i_alu_rd;
      w_sel_data = i_alu_wdata;
    end else if (w_fifo_ne) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = r_fifo_rd[r_rptr];
      w_sel_data = r_fifo_data[r_rptr];
    end else if (w_lsu_acc) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = i_lsu_rd;
      w_sel_data = i_lsu_wdata;
    end else begin
      w_sel_we   = 1'b0;
    end
  end

  // Set applied after clear so a same-edge issue of a retiring rd stays pending.
  assign w_clr_mask    = w_sel_we ? (32'd1 << w_sel_rd) : 32'd0;
  assign w_set_mask    = (i_issue_valid && (i_issue_rd != 5'd0)) ? (32'd1 << i_issue_rd) : 32'd0;
  assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_rd[i]   <= 5'd0;
        r_fifo_data[i] <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo_rd[r_wptr]   <= i_lsu_rd;
        r_fifo_data[r_wptr] <= i_lsu_wdata;
        r_wptr              <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= 32'd0;
      r_pending   <= 32'd0;
      r_fwd1_en   <= 1'b0;
      r_fwd1_data <= 32'd0;
      r_fwd2_en   <= 1'b0;
      r_fwd2_data <= 32'd0;
    end else begin
      r_we      <= w_sel_we;
      r_pending <= w_pending_nxt;
      if (w_sel_we) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
      // The RAM returns stale data for the write on this edge; flag it one cycle on.
      if (r_we && (r_waddr == i_raddr1) && (r_waddr != 5'd0)) begin
        r_fwd1_en   <= 1'b1;
        r_fwd1_data <= r_wdata;
      end else begin
        r_fwd1_en   <= 1'b0;
      end
      if (r_we && (r_waddr == i_raddr2) && (r_waddr != 5'd0)) begin
        r_fwd2_en   <= 1'b1;
        r_fwd2_data <= r_wdata;
      end else begin
        r_fwd2_en   <= 1'b0;
      end
    end
  end

  assign o_lsu_ready = w_lsu_ready;
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_fwd1_en   = r_fwd1_en;
  assign o_fwd1_data = r_fwd1_data;
  assign o_fwd2_en   = r_fwd2_en;
  assign o_fwd2_data = r_fwd2_data;
  assign o_pending   = r_pending;
  assign o_busy      = w_fifo_ne || r_we;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_rf_writeback_ctrl;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_wdata;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_wdata;
  logic        o_lsu_ready;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [4:0]  i_raddr1;
  logic [4:0]  i_raddr2;
  logic        o_fwd1_en;
  logic [31:0] o_fwd1_data;
  logic        o_fwd2_en;
  logic [31:0] o_fwd2_data;
  logic [31:0] o_pending;
  logic        o_busy;

  rf_writeback_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_wdata(i_alu_wdata),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_wdata(i_lsu_wdata),
    .o_lsu_ready(o_lsu_ready),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_fwd1_en(o_fwd1_en), .o_fwd1_data(o_fwd1_data),
    .o_fwd2_en(o_fwd2_en), .o_fwd2_data(o_fwd2_data),
    .o_pending(o_pending), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a queue of deferred LSU writes plus the visible write port.
  logic [36:0] m_q[$];
  logic        m_valid = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_pending = 32'd0;
  logic        m_fwd1_en = 1'b0;
  logic [31:0] m_fwd1_data = 32'd0;
  logic        m_fwd2_en = 1'b0;
  logic [31:0] m_fwd2_data = 32'd0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic        acc;
    logic        we_n;
    logic [4:0]  wa_n;
    logic [31:0] wd_n;
    logic [36:0] e;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b1;
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_pending = 32'd0;
      m_fwd1_en = 1'b0; m_fwd1_data = 32'd0; m_fwd2_en = 1'b0; m_fwd2_data = 32'd0;
    end else begin
      acc  = i_lsu_valid && (m_q.size() < DEPTH) && (i_lsu_rd != 5'd0);
      we_n = 1'b1;
      wa_n = m_waddr;
      wd_n = m_wdata;
      if (i_alu_valid && i_alu_rd != 5'd0) begin
        wa_n = i_alu_rd; wd_n = i_alu_wdata;
        if (acc) m_q.push_back({i_lsu_rd, i_lsu_wdata});
      end else if (m_q.size() != 0) begin
        e = m_q.pop_front();
        wa_n = e[36:32]; wd_n = e[31:0];
        if (acc) m_q.push_back({i_lsu_rd, i_lsu_wdata});
      end else if (acc) begin
        wa_n = i_lsu_rd; wd_n = i_lsu_wdata;
      end else begin
        we_n = 1'b0;
      end
      if (m_we && m_waddr == i_raddr1 && m_waddr != 5'd0) begin
        m_fwd1_en = 1'b1; m_fwd1_data = m_wdata;
      end else begin
        m_fwd1_en = 1'b0;
      end
      if (m_we && m_waddr == i_raddr2 && m_waddr != 5'd0) begin
        m_fwd2_en = 1'b1; m_fwd2_data = m_wdata;
      end else begin
        m_fwd2_en = 1'b0;
      end
      if (we_n) m_pending[wa_n] = 1'b0;
      if (i_issue_valid && i_issue_rd != 5'd0) m_pending[i_issue_rd] = 1'b1;
      m_we = we_n; m_waddr = wa_n; m_wdata = wd_n;
    end
  endtask

  task automatic model_compare();
    if (m_valid) begin
      cmp("m_we", {31'd0, o_we}, {31'd0, m_we});
      cmp("m_waddr", {27'd0, o_waddr}, {27'd0, m_waddr});
      cmp("m_wdata", o_wdata, m_wdata);
      cmp("m_pending", o_pending, m_pending);
      cmp("m_lsu_ready", {31'd0, o_lsu_ready}, {31'd0, (m_q.size() < DEPTH)});
      cmp("m_busy", {31'd0, o_busy}, {31'd0, (m_q.size() != 0) || m_we});
      cmp("m_fwd1_en", {31'd0, o_fwd1_en}, {31'd0, m_fwd1_en});
      cmp("m_fwd2_en", {31'd0, o_fwd2_en}, {31'd0, m_fwd2_en});
      if (m_fwd1_en) cmp("m_fwd1_data", o_fwd1_data, m_fwd1_data);
      if (m_fwd2_en) cmp("m_fwd2_data", o_fwd2_data, m_fwd2_data);
      if (!rst && i_issue_valid && i_issue_rd != 5'd0)
        cmp("issue_not_pending", {31'd0, m_pending[i_issue_rd]}, 32'd0);
    end
  endtask

  // One clock: compare on the falling edge, advance model on the rising edge.
  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int   exp4 [7] = '{10, 11, 12, 13, 1, 2, 3};
  int   lidx;
  logic rdy;

  initial begin
    rst = 1'b1;
    i_issue_valid = 1'b0; i_issue_rd = 5'd0;
    i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_wdata = 32'd0;
    i_lsu_valid = 1'b0; i_lsu_rd = 5'd0; i_lsu_wdata = 32'd0;
    i_raddr1 = 5'd0; i_raddr2 = 5'd0;

    // 1: reset and idle
    tick(); tick();
    rst = 1'b0;
    tick();
    cmp("t1_we", {31'd0, o_we}, 32'd0);
    cmp("t1_pending", o_pending, 32'd0);
    cmp("t1_ready", {31'd0, o_lsu_ready}, 32'd1);
    cmp("t1_busy", {31'd0, o_busy}, 32'd0);
    cmp("t1_fwd1", {31'd0, o_fwd1_en}, 32'd0);
    cmp("t1_fwd2", {31'd0, o_fwd2_en}, 32'd0);

    // 2: issue x5, then ALU writeback clears it
    i_issue_valid = 1'b1; i_issue_rd = 5'd5;
    tick();
    cmp("t2_pend_set", o_pending, 32'h0000_0020);
    i_issue_valid = 1'b0;
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_wdata = 32'h0000_1234;
    tick();
    i_alu_valid = 1'b0;
    cmp("t2_we", {31'd0, o_we}, 32'd1);
    cmp("t2_waddr", {27'd0, o_waddr}, 32'd5);
    cmp("t2_wdata", o_wdata, 32'h0000_1234);
    cmp("t2_pend_clr", o_pending, 32'd0);

    // 3: ALU and LSU collide; LSU deferred one cycle
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_wdata = 32'h0000_000A;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_wdata = 32'h0000_000B;
    tick();
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    cmp("t3_a_waddr", {27'd0, o_waddr}, 32'd3);
    cmp("t3_a_wdata", o_wdata, 32'h0000_000A);
    cmp("t3_a_busy", {31'd0, o_busy}, 32'd1);
    tick();
    cmp("t3_b_we", {31'd0, o_we}, 32'd1);
    cmp("t3_b_waddr", {27'd0, o_waddr}, 32'd7);
    cmp("t3_b_wdata", o_wdata, 32'h0000_000B);
    cmp("t3_b_busy", {31'd0, o_busy}, 32'd1);
    tick();
    cmp("t3_idle_we", {31'd0, o_we}, 32'd0);

    // 4: ALU stream starves LSU; FIFO fills, then drains in order
    lidx = 1;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd1; i_lsu_wdata = 32'h0000_0201;
    for (int i = 0; i < 7; i++) begin
      i_alu_valid = (i < 4);
      i_alu_rd    = 5'(10 + i);
      i_alu_wdata = 32'h0000_0100 + 32'(i);
      rdy = o_lsu_ready;
      tick();
      if (rdy && i_lsu_valid) begin
        lidx++;
        if (lidx > 3) begin
          i_lsu_valid = 1'b0;
        end else begin
          i_lsu_rd = 5'(lidx);
          i_lsu_wdata = 32'h0000_0200 + 32'(lidx);
        end
      end
      cmp("t4_we", {31'd0, o_we}, 32'd1);
      cmp("t4_waddr", {27'd0, o_waddr}, 32'(exp4[i]));
      if (i == 1) cmp("t4_ready_full", {31'd0, o_lsu_ready}, 32'd0);
      if (i == 5) cmp("t4_ready_again", {31'd0, o_lsu_ready}, 32'd1);
    end
    cmp("t4_last_wdata", o_wdata, 32'h0000_0203);
    i_alu_valid = 1'b0;
    tick();

    // 5: forwarding alignment
    i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_wdata = 32'hDEAD_BEEF;
    tick();
    i_alu_valid = 1'b0; i_raddr1 = 5'd9; i_raddr2 = 5'd4;
    tick();
    cmp("t5_fwd1_en", {31'd0, o_fwd1_en}, 32'd1);
    cmp("t5_fwd1_data", o_fwd1_data, 32'hDEAD_BEEF);
    cmp("t5_fwd2_en", {31'd0, o_fwd2_en}, 32'd0);
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_wdata = 32'h1111_1111; i_raddr1 = 5'd0;
    tick();
    i_alu_valid = 1'b0;
    tick();
    cmp("t5_x0_fwd1_en", {31'd0, o_fwd1_en}, 32'd0);
    i_alu_valid = 1'b1; i_alu_rd = 5'd4; i_alu_wdata = 32'h0000_0044;
    tick();
    i_alu_valid = 1'b0;
    tick();
    cmp("t5_fwd2_en", {31'd0, o_fwd2_en}, 32'd1);
    cmp("t5_fwd2_data", o_fwd2_data, 32'h0000_0044);
    i_raddr2 = 5'd0;

    // 6: x0 writes dropped, set-wins scoreboard, reset discards FIFO
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_wdata = 32'h0000_0055;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_wdata = 32'h0000_0056;
    tick();
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    cmp("t6_x0_we", {31'd0, o_we}, 32'd0);
    cmp("t6_x0_busy", {31'd0, o_busy}, 32'd0);
    i_alu_valid = 1'b1; i_alu_rd = 5'd6; i_alu_wdata = 32'h0000_0066;
    i_issue_valid = 1'b1; i_issue_rd = 5'd6;
    tick();
    i_issue_valid = 1'b0;
    cmp("t6_setwins", o_pending, 32'h0000_0040);
    cmp("t6_x6_waddr", {27'd0, o_waddr}, 32'd6);
    i_alu_rd = 5'd20; i_alu_wdata = 32'h0000_0020;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd21; i_lsu_wdata = 32'h0000_0021;
    tick();
    i_alu_rd = 5'd22; i_alu_wdata = 32'h0000_0022;
    i_lsu_rd = 5'd23; i_lsu_wdata = 32'h0000_0023;
    tick();
    cmp("t6_full_ready", {31'd0, o_lsu_ready}, 32'd0);
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("t6_rst_we", {31'd0, o_we}, 32'd0);
    cmp("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    cmp("t6_rst_pending", o_pending, 32'd0);
    cmp("t6_rst_ready", {31'd0, o_lsu_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t6_no_stale_we", {31'd0, o_we}, 32'd0);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side controller for the 32x32 dual-read-port register-file RAM. It owns that RAM's single write port.
- Merges writebacks from the ALU (no backpressure) and the load/store unit (LSU, ready/valid) into one registered write stream.
- Keeps a pending-register scoreboard that the issue stage uses for stalling.
- Produces read-during-write forwarding flags aligned with the RAM's synchronous read data. The RAM returns old data when a read and a write hit the same address on the same edge.

Parameters:
- FIFO_DEPTH, 2, entries in the deferred LSU write queue (power of 2, minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_issue_valid  in  1  instruction issued that will write i_issue_rd
- i_issue_rd  in  5  destination register of the issued instruction
- i_alu_valid  in  1  ALU writeback valid; always accepted
- i_alu_rd  in  5  ALU destination register
- i_alu_wdata  in  32  ALU result
- i_lsu_valid  in  1  LSU writeback valid
- i_lsu_rd  in  5  LSU destination register
- i_lsu_wdata  in  32  LSU load data
- o_lsu_ready  out  1  LSU writeback accepted this cycle when valid && ready
- o_we  out  1  RAM write enable (registered)
- o_waddr  out  5  RAM write address (registered)
- o_wdata  out  32  RAM write data (registered)
- i_raddr1  in  5  read address 1, same value driven to the RAM
- i_raddr2  in  5  read address 2, same value driven to the RAM
- o_fwd1_en  out  1  replace RAM o_rdata1 with o_fwd1_data
- o_fwd1_data  out  32  forwarded data for port 1
- o_fwd2_en  out  1  replace RAM o_rdata2 with o_fwd2_data
- o_fwd2_data  out  32  forwarded data for port 2
- o_pending  out  32  scoreboard; bit r=1 means a write to xr is outstanding
- o_busy  out  1  FIFO non-empty or o_we=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_we, o_waddr, o_wdata, o_fwd*_en, o_fwd*_data and o_pending all go to 0.
  - FIFO is emptied; any queued writes are discarded.
  - o_lsu_ready=1 from the first cycle after reset (it is combinational from the FIFO count).
- x0 handling:
  - Writes with rd=0 are accepted but never reach the FIFO or o_we.
  - An issue with rd=0 sets no scoreboard bit; o_pending[0] is always 0.
- Per-cycle write selection (the selected write is registered into o_we/o_waddr/o_wdata at the edge, giving 1-cycle latency):
  - ALU valid with rd!=0: select the ALU write.
  - Else, FIFO non-empty: pop the head and select it.
  - Else, LSU valid && ready with rd!=0: select the LSU write directly.
  - Else: o_we<=0. o_waddr/o_wdata hold their previous values.
- LSU enqueue:
  - An accepted LSU write (rd!=0) is pushed to the FIFO when the ALU is selected or the FIFO is non-empty. This preserves LSU order.
  - Push and pop in the same cycle are allowed.
- o_lsu_ready = (FIFO count < FIFO_DEPTH). It is combinational and does not account for a same-cycle pop.
- ALU writes have no backpressure; the ALU is never stalled.
- Scoreboard:
  - Set: issue (rd!=0) sets bit rd at the edge.
  - Clear: bit r is cleared at the edge where a write to r is registered into o_we.
  - Set and clear of the same rd on the same edge: set wins.
- Issue precondition: the issue stage never issues an instruction whose rd is already pending. No two writes to the same rd are in flight, so ALU/LSU reordering is safe. The bench asserts this.
- Forwarding, evaluated at each edge:
  - o_fwd1_en <= o_we && o_waddr==i_raddr1 && o_waddr!=0.
  - o_fwd1_data <= o_wdata.
  - Port 2 is identical using i_raddr2.
  - Result: fwd outputs are valid in the same cycle as the RAM's o_rdata for that address.
  - When o_fwd*_en=0, o_fwd*_data holds its previous value and is don't-care.
- o_busy = (FIFO count != 0) || o_we.

Test Plan:
1. Reset sequence, then idle -> o_we=0, o_pending=0, o_lsu_ready=1, o_busy=0, both fwd_en=0.
2. Issue rd=5; one cycle later, ALU valid rd=5 data 0x00001234 -> next cycle o_we=1, o_waddr=5, o_wdata=0x00001234, o_pending[5] 1->0.
3. ALU rd=3 data 0xA and LSU rd=7 data 0xB in the same cycle -> cycle+1 writes x3=0xA; cycle+2 writes x7=0xB; o_busy=1 throughout.
4. ALU valid for 4 consecutive cycles while LSU presents rd=1,2,3 -> o_lsu_ready=0 after 2 LSU writes are queued; when the ALU stops, x1 then x2 are written, then x3 is accepted; in-order x1,x2,x3 is observed.
5. o_we=1, o_waddr=9, o_wdata=0xDEADBEEF with i_raddr1=9, i_raddr2=4 -> next cycle o_fwd1_en=1, o_fwd1_data=0xDEADBEEF, o_fwd2_en=0. Repeat with waddr=0 and raddr1=0 -> o_fwd1_en=0.
6. ALU rd=0 and LSU rd=0 -> no o_we, FIFO stays empty. Issue rd=6 on the same edge that a write to x6 registers -> o_pending[6]=1. Assert rst while the FIFO holds 2 entries -> FIFO empty, o_we=0 and those writes are never written.
